// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle logic/arith/shift ops plus
// sequential 32-iteration signed MULT/DIV engines writing HI/LO.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       ALU_Control,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_MULT = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;
    localparam logic [3:0] OP_SRA  = 4'b1010;
    localparam logic [3:0] OP_DIV  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic               neg_res;
    logic               neg_a;
    logic               is_div;
    logic               dbz_pend;

    logic               is_mult_op;
    logic               is_div_op;
    logic               b_zero;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic [WIDTH-1:0]   alu_res;
    logic               last_iter;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [WIDTH-1:0]   rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign is_mult_op = (ALU_Control == OP_MULT);
    assign is_div_op  = (ALU_Control == OP_DIV);
    assign b_zero     = (B == '0);
    assign abs_a      = A[WIDTH-1] ? -A : A;
    assign abs_b      = B[WIDTH-1] ? -B : B;
    assign last_iter  = (cnt == CW'(WIDTH - 1));

    always_comb begin
        alu_res = '0;
        case (ALU_Control)
            OP_AND:  alu_res = A & B;
            OP_OR:   alu_res = A | B;
            OP_ADD:  alu_res = A + B;
            OP_SUB:  alu_res = A - B;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            OP_SLL:  alu_res = B << shamt;
            OP_SRL:  alu_res = B >> shamt;
            OP_SRA:  alu_res = $signed(B) >>> shamt;
            OP_NOR:  alu_res = ~(A | B);
            OP_XOR:  alu_res = A ^ B;
            default: alu_res = '0;
        endcase
    end

    // Shift-add step: add multiplicand into upper half, then shift right
    always_comb begin
        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, opb};
        mul_next = prod[0] ? {mul_sum, prod[WIDTH-1:1]}
                           : {1'b0, prod[2*WIDTH-1:1]};
    end

    // Restoring divide step: keep the trial subtraction only if non-negative
    always_comb begin
        div_shift = {rem, quo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opb};
        if (!div_diff[WIDTH]) begin
            rem_next = div_diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = div_shift[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

    always_comb begin
        prod_signed = neg_res ? -prod : prod;
        fix_hi      = prod_signed[2*WIDTH-1:WIDTH];
        fix_lo      = prod_signed[WIDTH-1:0];
        if (is_div) begin
            fix_lo = neg_res ? -quo : quo;
            fix_hi = neg_a ? -rem : rem;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start && is_mult_op)
                    state_nx = MUL;
                else if (start && is_div_op)
                    state_nx = b_zero ? FIX : DIV;
            end
            MUL:  if (last_iter) state_nx = FIX;
            DIV:  if (last_iter) state_nx = FIX;
            FIX:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result      <= '0;
            zero        <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            cnt         <= '0;
            prod        <= '0;
            opb         <= '0;
            quo         <= '0;
            rem         <= '0;
            neg_res     <= 1'b0;
            neg_a       <= 1'b0;
            is_div      <= 1'b0;
            dbz_pend    <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        div_by_zero <= 1'b0;
                        if (is_mult_op || is_div_op) begin
                            busy     <= 1'b1;
                            cnt      <= '0;
                            prod     <= {{WIDTH{1'b0}}, abs_a};
                            quo      <= abs_a;
                            rem      <= '0;
                            opb      <= abs_b;
                            neg_res  <= A[WIDTH-1] ^ B[WIDTH-1];
                            neg_a    <= A[WIDTH-1];
                            is_div   <= is_div_op;
                            dbz_pend <= is_div_op && b_zero;
                        end else begin
                            result <= alu_res;
                            zero   <= (alu_res == '0);
                            done   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    prod <= mul_next;
                    cnt  <= cnt + 1'b1;
                end
                DIV: begin
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt + 1'b1;
                end
                FIX: begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    if (dbz_pend) begin
                        // Divide by zero leaves HI/LO as they were
                        div_by_zero <= 1'b1;
                        result      <= lo;
                        zero        <= (lo == '0);
                    end else begin
                        hi     <= fix_hi;
                        lo     <= fix_lo;
                        result <= fix_lo;
                        zero   <= (fix_lo == '0);
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: per-feature tasks with a
// scoreboard queue of expected results popped when done pulses.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  ALU_Control;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        zero;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .start(start), .ALU_Control(ALU_Control),
        .A(A), .B(B), .shamt(shamt), .result(result), .zero(zero),
        .busy(busy), .done(done), .div_by_zero(div_by_zero),
        .hi(hi), .lo(lo)
    );

    typedef struct {
        logic [31:0] res;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;
    int          passed = 0;
    int          total  = 0;
    int          last_lat;
    bit          busy_drop;

    // Reference model; lat counts clock edges after the start edge until done
    function automatic exp_t model(input logic [3:0] code, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t        e;
        longint      p, q, r;
        logic [63:0] pv;
        e.dbz = 1'b0;
        e.lat = 0;
        e.res = 32'd0;
        case (code)
            4'b0000: e.res = a & b;
            4'b0001: e.res = a | b;
            4'b0010: e.res = a + b;
            4'b0110: e.res = a - b;
            4'b0111: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'b1000: e.res = b << sh;
            4'b1001: e.res = b >> sh;
            4'b1010: e.res = $signed(b) >>> sh;
            4'b1100: e.res = ~(a | b);
            4'b0100: e.res = a ^ b;
            4'b0101: begin
                p = longint'($signed(a)) * longint'($signed(b));
                pv = p;
                m_hi = pv[63:32];
                m_lo = pv[31:0];
                e.res = m_lo;
                e.lat = 33;
            end
            4'b1011: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                    e.res = m_lo;
                    e.lat = 1;
                end else begin
                    q = longint'($signed(a)) / longint'($signed(b));
                    r = longint'($signed(a)) % longint'($signed(b));
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                    e.res = m_lo;
                    e.lat = 33;
                end
            end
            default: e.res = 32'd0;
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
        return e;
    endfunction

    task automatic issue(input logic [3:0] code, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh);
        @(negedge clk);
        ALU_Control = code;
        A = a;
        B = b;
        shamt = sh;
        start = 1'b1;
        sb.push_back(model(code, a, b, sh));
        @(posedge clk);
        #1;
        start = 1'b0;
        last_lat = 0;
        busy_drop = 1'b0;
        while (done !== 1'b1 && last_lat < 100) begin
            if (busy !== 1'b1) busy_drop = 1'b1;
            @(posedge clk);
            #1;
            last_lat++;
        end
    endtask

    task automatic test_reset;
        total++;
        if (result !== 32'd0 || zero !== 1'b1) $display("FAIL reset_result: got res=%h zero=%b want res=0 zero=1", result, zero);
        else passed++;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) $display("FAIL reset_busy_done: got busy=%b done=%b want 0 0", busy, done);
        else passed++;
        total++;
        if (hi !== 32'd0 || lo !== 32'd0 || div_by_zero !== 1'b0) $display("FAIL reset_hilo: got hi=%h lo=%h dbz=%b want 0 0 0", hi, lo, div_by_zero);
        else passed++;
    endtask

    task automatic test_logic;
        logic [3:0] c [4];
        exp_t e;
        c = '{4'b0000, 4'b0001, 4'b0100, 4'b1100};
        for (int i = 0; i < 4; i++) begin
            issue(c[i], 32'hF0F0F0F0, 32'h0FF00FF0, 5'd0);
            e = sb.pop_front();
            total++;
            if ({result, zero, hi, lo, div_by_zero} !== {e.res, e.res == 32'd0, e.hi, e.lo, e.dbz} || last_lat != e.lat)
                $display("FAIL logic_op%0d: got res=%h z=%b hi=%h lo=%h lat=%0d want res=%h hi=%h lo=%h lat=%0d",
                         i, result, zero, hi, lo, last_lat, e.res, e.hi, e.lo, e.lat);
            else passed++;
        end
    endtask

    task automatic test_arith;
        logic [3:0]  c [8];
        logic [31:0] a [8];
        logic [31:0] b [8];
        logic [4:0]  s [8];
        exp_t e;
        c = '{4'b0110, 4'b0010, 4'b0111, 4'b0111, 4'b1010, 4'b1001, 4'b1000, 4'b0011};
        a = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd12};
        b = '{32'd5, 32'd1, 32'd1, 32'hFFFFFFFF, 32'h80000000, 32'h80000000, 32'd1, 32'd34};
        s = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd4, 5'd4, 5'd31, 5'd0};
        for (int i = 0; i < 8; i++) begin
            issue(c[i], a[i], b[i], s[i]);
            e = sb.pop_front();
            total++;
            if ({result, zero, hi, lo} !== {e.res, e.res == 32'd0, e.hi, e.lo} || last_lat != e.lat)
                $display("FAIL arith_%0d: got res=%h z=%b hi=%h lo=%h lat=%0d want res=%h hi=%h lo=%h lat=%0d",
                         i, result, zero, hi, lo, last_lat, e.res, e.hi, e.lo, e.lat);
            else passed++;
        end
    endtask

    task automatic test_mult;
        logic [31:0] a, b;
        exp_t e;
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 32'hFFFFFFFD : $urandom;
            b = (i == 0) ? 32'd7 : $urandom;
            issue(4'b0101, a, b, 5'd0);
            e = sb.pop_front();
            total++;
            if ({result, hi, lo} !== {e.res, e.hi, e.lo} || last_lat != e.lat)
                $display("FAIL mult_%0d: a=%h b=%h got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                         i, a, b, hi, lo, last_lat, e.hi, e.lo, e.lat);
            else passed++;
            total++;
            if (busy_drop || busy !== 1'b0)
                $display("FAIL mult_busy_%0d: busy dropped early=%b busy at done=%b want 0 0", i, busy_drop, busy);
            else passed++;
        end
    endtask

    task automatic test_div;
        logic [3:0]  c [8];
        logic [31:0] a [8];
        logic [31:0] b [8];
        exp_t e;
        c = '{4'b1011, 4'b1011, 4'b0000, 4'b1011, 4'b1011, 4'b1011, 4'b1011, 4'b1011};
        a = '{32'hFFFFFFF9, 32'd9, 32'd3, 32'h80000000, 32'd7, 32'd0, $urandom, $urandom};
        b = '{32'd2, 32'd0, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd5, $urandom | 32'd1, $urandom_range(1, 1000)};
        for (int i = 0; i < 8; i++) begin
            issue(c[i], a[i], b[i], 5'd0);
            e = sb.pop_front();
            total++;
            if ({result, zero, hi, lo, div_by_zero} !== {e.res, e.res == 32'd0, e.hi, e.lo, e.dbz} || last_lat != e.lat)
                $display("FAIL div_%0d: a=%h b=%h got res=%h hi=%h lo=%h dbz=%b lat=%0d want res=%h hi=%h lo=%h dbz=%b lat=%0d",
                         i, a[i], b[i], result, hi, lo, div_by_zero, last_lat, e.res, e.hi, e.lo, e.dbz, e.lat);
            else passed++;
        end
    endtask

    task automatic test_busy_ignore;
        exp_t e;
        int lat, extra;
        @(negedge clk);
        ALU_Control = 4'b0101;
        A = 32'd6;
        B = 32'd7;
        start = 1'b1;
        sb.push_back(model(4'b0101, 32'd6, 32'd7, 5'd0));
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            if (lat == 3 || lat == 10 || lat == 20) begin
                ALU_Control = 4'b1011;
                A = 32'd100;
                B = 32'd3;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        e = sb.pop_front();
        total++;
        if ({result, hi, lo} !== {e.res, e.hi, e.lo} || lat != e.lat)
            $display("FAIL busy_ignore: got res=%h hi=%h lo=%h lat=%0d want res=%h hi=%h lo=%h lat=%0d",
                     result, hi, lo, lat, e.res, e.hi, e.lo, e.lat);
        else passed++;
        extra = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        total++;
        if (extra != 0) $display("FAIL busy_ignore_queued: got %0d cycles with done/busy want 0", extra);
        else passed++;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        issue(4'b0101, 32'd5, 32'hFFFFFFFC, 5'd0);
        e = sb.pop_front();
        total++;
        if ({hi, lo} !== {e.hi, e.lo} || last_lat != e.lat)
            $display("FAIL b2b_mult: got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d", hi, lo, last_lat, e.hi, e.lo, e.lat);
        else passed++;
        total++;
        if (done !== 1'b1) $display("FAIL b2b_done_cycle: got done=%b want 1", done);
        else passed++;
        issue(4'b0010, 32'd10, 32'd20, 5'd0);
        e = sb.pop_front();
        total++;
        if ({result, hi, lo} !== {e.res, e.hi, e.lo} || last_lat != e.lat)
            $display("FAIL b2b_add: got res=%h hi=%h lo=%h lat=%0d want res=%h hi=%h lo=%h lat=%0d",
                     result, hi, lo, last_lat, e.res, e.hi, e.lo, e.lat);
        else passed++;
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int dcount;
        @(negedge clk);
        ALU_Control = 4'b0101;
        A = 32'd123;
        B = 32'd456;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL reset_mid_state: got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
        else passed++;
        total++;
        if (result !== 32'd0 || zero !== 1'b1)
            $display("FAIL reset_mid_result: got res=%h zero=%b want 0 1", result, zero);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        dcount = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        total++;
        if (dcount != 0) $display("FAIL reset_mid_done: got %0d done pulses want 0", dcount);
        else passed++;
        issue(4'b0010, 32'd2, 32'd3, 5'd0);
        e = sb.pop_front();
        total++;
        if ({result, hi, lo} !== {e.res, e.hi, e.lo} || last_lat != e.lat)
            $display("FAIL reset_mid_add: got res=%h hi=%h lo=%h lat=%0d want res=%h hi=%h lo=%h lat=%0d",
                     result, hi, lo, last_lat, e.res, e.hi, e.lo, e.lat);
        else passed++;
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        ALU_Control = 4'd0;
        A = 32'd0;
        B = 32'd0;
        shamt = 5'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_logic();
        test_arith();
        test_mult();
        test_div();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
